// File: rtl/wisc_mem_pkg.sv
// Shared types and default widths for the unified-memory arbiter.
package wisc_mem_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_DM
  } owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the single-ported unified memory between Fetch and the Memory stage,
// sequencing one fixed-latency access at a time and pulsing the owner's valid.
module mem_arbiter
  import wisc_mem_pkg::*;
#(
  parameter int MEM_LAT = 4,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_req,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  arb_state_t        state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic              dm_valid_q, dm_valid_d;

  always_comb begin
    // NOTE: every _d defaults to hold (or to 0 for pulses) before the case so no path infers a latch.
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    mem_en_d    = 1'b0;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_valid_d  = 1'b0;
    dm_valid_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Data wins: the Memory stage holds the older instruction.
        if (dm_req) begin
          owner_d     = OWN_DM;
          mem_wr_d    = dm_wr;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          mem_en_d    = 1'b1;
          state_d     = ISSUE;
        end else if (if_req) begin
          owner_d    = OWN_IF;
          mem_wr_d   = 1'b0;
          mem_addr_d = if_addr;
          mem_en_d   = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = LAT;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          if (owner_q == OWN_DM) begin
            dm_valid_d = 1'b1;
            if (!mem_wr_q) dm_rdata_d = mem_rdata;
          end else begin
            if_valid_d = 1'b1;
            if_rdata_d = mem_rdata;
          end
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; the comb block above uses blocking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      cnt_q       <= 4'd0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_valid_q  <= if_valid_d;
      dm_valid_q  <= dm_valid_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_valid  = if_valid_q;
  assign dm_valid  = dm_valid_q;
  assign stall_if  = if_req & ~if_valid_q;
  assign stall_mem = dm_req & ~dm_valid_q;

endmodule
